serial_cmd_decoder: RTL and testbench
=====================================

# serial_cmd_decoder

Host-facing command decoder that sits behind the UART receive side. It consumes ASCII bytes from the UART (`rxd`/`rxd_strobe`) and turns hex command lines from the PC into register write and read strobes. It sends short ASCII replies back through the UART transmit handshake (`txd`/`txd_strobe`/`txd_ready`). This lets the FTDI port control board registers (LEDs, debug regs) instead of only printing to the host.

## Interface
- `ACK_CHAR`, default `"K"`: reply byte after a successful write.
- `ERR_CHAR`, default `"?"`: reply byte after a malformed line.
- `TIMEOUT`, default `120_000_000`: idle clocks mid-line before the partial line is abandoned; 0 disables the timeout.
- `clk`  in  1  system clock (120 MHz in current top)
- `reset`  in  1  synchronous, active-high
- `rxd`  in  8  received byte; valid when `rxd_strobe`=1
- `rxd_strobe`  in  1  one-cycle pulse per received byte
- `txd`  out  8  byte to transmit
- `txd_strobe`  out  1  one-cycle pulse; UART latches `txd`
- `txd_ready`  in  1  UART transmitter idle
- `reg_addr`  out  8  address of current access
- `wr_data`  out  8  write data
- `wr_strobe`  out  1  one-cycle write pulse
- `rd_strobe`  out  1  one-cycle read pulse
- `rd_data`  in  8  read data; sampled exactly 1 cycle after `rd_strobe`

## Operation
- Grammar (hex digits case-insensitive, terminator is CR 0x0D or LF 0x0A):
  - Write: `W` or `w`, then 2 hex address digits, then 2 hex data digits, then terminator.
  - Read: `R` or `r`, then 2 hex address digits, then terminator.
- States: IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, TERM, EXEC, RD_WAIT, REPLY, DISCARD.
- IDLE:
  - A terminator is ignored, so CRLF produces no extra reply.
  - `W` or `R` latches the opcode and goes to ADDR_HI.
  - Any other byte goes to DISCARD.
- Nibble states: a valid hex digit shifts into the address or data register. Any other byte goes to DISCARD. A terminator arriving early counts as an error, and the error reply is sent immediately.
- TERM: a terminator goes to EXEC; any other byte goes to DISCARD.
- DISCARD: drops bytes until a terminator, then queues `ERR_CHAR` and goes to REPLY.
- EXEC, write: pulse `wr_strobe`, queue `ACK_CHAR`, go to REPLY.
- EXEC, read: pulse `rd_strobe`, go to RD_WAIT. Next cycle capture `rd_data` and queue two uppercase hex ASCII chars, high nibble first.
- REPLY:
  - Send the queued bytes (1 or 2).
  - `rxd_strobe` bytes arriving in REPLY are dropped; the host waits for the reply.
  - After the last byte is strobed, return to IDLE.
- Timeout:
  - The counter resets on every `rxd_strobe` and counts only in ADDR_HI..TERM and DISCARD.
  - When it reaches `TIMEOUT`, return to IDLE silently with no reply.
- `reg_addr` and `wr_data` hold their values until the next line modifies them.

## Timing
- Reset values: `txd`=0, `txd_strobe`=0, `wr_strobe`=0, `rd_strobe`=0, `reg_addr`=0, `wr_data`=0, state IDLE, timeout counter 0. A reset mid-line or mid-reply abandons it; no partial reply is sent.
- Each byte is consumed in its `rxd_strobe` cycle; no input buffering.
- Write: `wr_strobe` asserts 1 cycle after the terminator's strobe cycle, with `reg_addr`/`wr_data` stable in that cycle.
- Read: `rd_strobe` asserts 1 cycle after the terminator; `rd_data` is captured on the following edge.
- TX handshake:
  - Assert `txd_strobe` only when `txd_ready`=1 and `txd_strobe` was 0 in the previous cycle. This gives the UART one cycle to drop ready.
  - `txd` is valid in the strobe cycle and held until the next strobe.
  - The earliest first reply byte is 1 cycle after entering REPLY.
- Hex output: nibble 0..9 maps to 0x30+n; 10..15 maps to 0x37+n.

## Structure
- Shared package `serial_cmd_pkg`:
  - ASCII constants: CR, LF, `W`, `w`, `R`, `r`.
  - State enum.
  - Functions `ascii_to_nibble` (returns valid flag + 4-bit value) and `nibble_to_ascii`.
- One sub-module: `byte_reply_tx`. It holds a 2-entry reply queue plus the `txd_ready`/`txd_strobe` handshake logic, and signals `done` to the parser FSM.

## Test plan
- Write: "W3CA5\r" → exactly one `wr_strobe`, with `reg_addr`=0x3C and `wr_data`=0xA5; exactly one `txd_strobe` with `txd`=0x4B.
- Read: "r3c\n" with `rd_data`=0x7E → one `rd_strobe` with `reg_addr`=0x3C; `txd` sequence 0x37, 0x45; no `wr_strobe`.
- Errors:
  - "WZ1A5\r", "W12\r" and "W12345\r" each produce no `wr_strobe` and a single 0x3F.
  - "\r\n" alone produces no reply.
- Backpressure: hold `txd_ready`=0 for 100 cycles during a read reply → no `txd_strobe` while low. Then both bytes go out with ≥1 cycle gap and no repeats.
- Reset mid-line: "W3C", then `reset`, then "A5\r" → `A` is treated as an unknown command, giving a single `?` and no `wr_strobe`.
- Timeout (`TIMEOUT`=1000): "W3", idle 1000 cycles, then "W0102\r" → one write of 0x02 to 0x01 and a single `K`; no `?`.

Source files
------------

// File: rtl/serial_cmd_pkg.sv
// Shared definitions for the host command decoder: ASCII codes, parser states, hex helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package serial_cmd_pkg;

  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam logic [7:0] ASCII_W_UPPER = 8'h57;
  localparam logic [7:0] ASCII_W_LOWER = 8'h77;
  localparam logic [7:0] ASCII_R_UPPER = 8'h52;
  localparam logic [7:0] ASCII_R_LOWER = 8'h72;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_TERM,
    ST_EXEC,
    ST_RD_WAIT,
    ST_REPLY,
    ST_DISCARD
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] val;
  } nibble_t;

  // Decode one ASCII hex digit (either case); vld=0 for anything else.
  function automatic nibble_t ascii_to_nibble(input logic [7:0] c);
    nibble_t n;
    n.vld = 1'b1;
    n.val = 4'h0;
    if (c >= 8'h30 && c <= 8'h39) begin
      n.val = c[3:0];
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so adding 9 lands on 10
      n.val = c[3:0] + 4'd9;
    end else begin
      n.vld = 1'b0;
    end
    return n;
  endfunction

  // Encode a nibble as an uppercase ASCII hex digit.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      return {4'h3, n};
    end
    return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/byte_reply_tx.sv
// Two-entry reply queue feeding the UART transmit handshake; o_done when the queue is empty.
// Latency: first byte no earlier than 1 cycle after load; successive bytes at least 1 idle cycle apart.
// Backpressure: a byte is strobed only while i_txd_ready=1 and no strobe was issued the cycle before.
module byte_reply_tx (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic       i_two,
  input  logic [7:0] i_byte0,
  input  logic [7:0] i_byte1,
  input  logic       i_txd_ready,
  output logic [7:0] o_txd,
  output logic       o_txd_strobe,
  output logic       o_done
);

  logic [7:0] r_q0;
  logic [7:0] r_q1;
  logic [7:0] r_txd;
  logic [1:0] r_cnt;
  logic       r_stb_d;
  logic       r_fresh;
  logic       w_fire;

  // r_fresh holds off the first byte for a cycle after loading; r_stb_d gives
  // the UART a cycle to drop ready after each strobe.
  assign w_fire       = !reset && (r_cnt != 2'd0) && !r_fresh && !r_stb_d && i_txd_ready;
  assign o_txd_strobe = w_fire;
  assign o_txd        = w_fire ? r_q0 : r_txd;
  assign o_done       = (r_cnt == 2'd0);

  // Queue load, shift-out on each strobe, and hold of the last transmitted byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q0    <= 8'h00;
      r_q1    <= 8'h00;
      r_txd   <= 8'h00;
      r_cnt   <= 2'd0;
      r_stb_d <= 1'b0;
      r_fresh <= 1'b0;
    end else begin
      r_stb_d <= w_fire;
      r_fresh <= i_load;
      if (i_load) begin
        r_q0  <= i_byte0;
        r_q1  <= i_byte1;
        r_cnt <= i_two ? 2'd2 : 2'd1;
      end else if (w_fire) begin
        r_txd <= r_q0;
        r_q0  <= r_q1;
        r_cnt <= r_cnt - 2'd1;
      end
    end
  end

endmodule

// File: rtl/serial_cmd_decoder.sv
// Parses ASCII hex W/R command lines into register write/read strobes and queues short ASCII replies.
// Latency: wr/rd strobe 1 cycle after the terminator byte; read data captured the cycle after rd_strobe.
// Backpressure: none on input (bytes during a reply are dropped); reply bytes wait on txd_ready.
module serial_cmd_decoder
  import serial_cmd_pkg::*;
#(
  parameter logic [7:0]  ACK_CHAR = 8'h4B,
  parameter logic [7:0]  ERR_CHAR = 8'h3F,
  parameter int unsigned TIMEOUT  = 120_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rxd,
  input  logic       rxd_strobe,
  output logic [7:0] txd,
  output logic       txd_strobe,
  input  logic       txd_ready,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_strobe,
  output logic       rd_strobe,
  input  logic [7:0] rd_data
);

  state_t      r_state;
  logic        r_is_wr;
  logic [7:0]  r_addr;
  logic [7:0]  r_data;
  logic [31:0] r_tcnt;

  state_t      w_state_nxt;
  logic        w_is_wr_nxt;
  logic [7:0]  w_addr_nxt;
  logic [7:0]  w_data_nxt;
  logic        w_load;
  logic        w_two;
  logic [7:0]  w_b0;
  logic [7:0]  w_b1;
  logic        w_done;
  logic        w_term;
  logic        w_counting;
  logic        w_tmo;
  nibble_t     w_nib;

  assign w_nib      = ascii_to_nibble(rxd);
  assign w_term     = (rxd == ASCII_CR) || (rxd == ASCII_LF);
  assign w_counting = r_state inside {ST_ADDR_HI, ST_ADDR_LO, ST_DATA_HI,
                                      ST_DATA_LO, ST_TERM, ST_DISCARD};
  // A byte arriving in the expiry cycle wins over the timeout.
  assign w_tmo      = (TIMEOUT != 0) && w_counting && !rxd_strobe && (r_tcnt == TIMEOUT);

  assign wr_strobe = (r_state == ST_EXEC) && r_is_wr;
  assign rd_strobe = (r_state == ST_EXEC) && !r_is_wr;
  assign reg_addr  = r_addr;
  assign wr_data   = r_data;

  // Parser state and the address/data shift registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_is_wr <= 1'b0;
      r_addr  <= 8'h00;
      r_data  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_is_wr <= w_is_wr_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Idle-timeout counter: cleared by every received byte and outside the mid-line states.
  always_ff @(posedge clk) begin
    if (reset || !w_counting || rxd_strobe || w_tmo || (TIMEOUT == 0)) begin
      r_tcnt <= 32'd0;
    end else begin
      r_tcnt <= r_tcnt + 32'd1;
    end
  end

  // Next-state decode, nibble shifting and reply queue loading.
  always_comb begin
    w_state_nxt = r_state;
    w_is_wr_nxt = r_is_wr;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_load      = 1'b0;
    w_two       = 1'b0;
    w_b0        = ERR_CHAR;
    w_b1        = 8'h00;
    unique case (r_state)
      ST_IDLE: begin
        if (rxd_strobe && !w_term) begin
          if (rxd == ASCII_W_UPPER || rxd == ASCII_W_LOWER) begin
            w_is_wr_nxt = 1'b1;
            w_state_nxt = ST_ADDR_HI;
          end else if (rxd == ASCII_R_UPPER || rxd == ASCII_R_LOWER) begin
            w_is_wr_nxt = 1'b0;
            w_state_nxt = ST_ADDR_HI;
          end else begin
            w_state_nxt = ST_DISCARD;
          end
        end
      end
      ST_ADDR_HI, ST_ADDR_LO, ST_DATA_HI, ST_DATA_LO: begin
        if (rxd_strobe) begin
          if (w_nib.vld) begin
            if (r_state == ST_ADDR_HI || r_state == ST_ADDR_LO) begin
              w_addr_nxt = {r_addr[3:0], w_nib.val};
            end else begin
              w_data_nxt = {r_data[3:0], w_nib.val};
            end
            case (r_state)
              ST_ADDR_HI: w_state_nxt = ST_ADDR_LO;
              ST_ADDR_LO: w_state_nxt = r_is_wr ? ST_DATA_HI : ST_TERM;
              ST_DATA_HI: w_state_nxt = ST_DATA_LO;
              default:    w_state_nxt = ST_TERM;
            endcase
          end else if (w_term) begin
            // Short line: the host already ended it, so answer right away.
            w_load      = 1'b1;
            w_state_nxt = ST_REPLY;
          end else begin
            w_state_nxt = ST_DISCARD;
          end
        end
      end
      ST_TERM: begin
        if (rxd_strobe) begin
          w_state_nxt = w_term ? ST_EXEC : ST_DISCARD;
        end
      end
      ST_EXEC: begin
        if (r_is_wr) begin
          w_load      = 1'b1;
          w_b0        = ACK_CHAR;
          w_state_nxt = ST_REPLY;
        end else begin
          w_state_nxt = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        w_load      = 1'b1;
        w_two       = 1'b1;
        w_b0        = nibble_to_ascii(rd_data[7:4]);
        w_b1        = nibble_to_ascii(rd_data[3:0]);
        w_state_nxt = ST_REPLY;
      end
      ST_REPLY: begin
        if (w_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (rxd_strobe && w_term) begin
          w_load      = 1'b1;
          w_state_nxt = ST_REPLY;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_tmo) begin
      w_state_nxt = ST_IDLE;
    end
  end

  byte_reply_tx u_reply_tx (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_load),
    .i_two        (w_two),
    .i_byte0      (w_b0),
    .i_byte1      (w_b1),
    .i_txd_ready  (txd_ready),
    .o_txd        (txd),
    .o_txd_strobe (txd_strobe),
    .o_done       (w_done)
  );

endmodule

// File: tb/tb_serial_cmd_decoder.sv
// Bench for serial_cmd_decoder: directed lines from the test plan plus randomized command lines.
// Latency: n/a.
// Backpressure: UART model drops txd_ready for a random 0..3 cycles after each strobe.
module tb_serial_cmd_decoder;

  localparam int unsigned TO = 1000;
  localparam logic [7:0]  CR = 8'h0D;
  localparam logic [7:0]  LF = 8'h0A;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rxd = 8'h00;
  logic       rxd_strobe = 1'b0;
  logic [7:0] txd;
  logic       txd_strobe;
  logic       txd_ready;
  logic [7:0] reg_addr;
  logic [7:0] wr_data;
  logic       wr_strobe;
  logic       rd_strobe;
  logic [7:0] rd_data = 8'h00;

  always #5 clk = ~clk;

  serial_cmd_decoder #(.ACK_CHAR(8'h4B), .ERR_CHAR(8'h3F), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .rxd_strobe(rxd_strobe),
    .txd(txd), .txd_strobe(txd_strobe), .txd_ready(txd_ready),
    .reg_addr(reg_addr), .wr_data(wr_data), .wr_strobe(wr_strobe),
    .rd_strobe(rd_strobe), .rd_data(rd_data)
  );

  int n_checks = 0;
  int n_errs   = 0;

  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  line_q[$];
  logic [7:0]  rd_val = 8'h00;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // UART model: busy for a random 0..3 cycles after each strobe, plus a forced-low override.
  int busy = 0;
  bit hold_low = 1'b0;
  assign txd_ready = (busy == 0) && !hold_low;
  always @(posedge clk) begin
    if (txd_strobe) busy <= $urandom_range(0, 3);
    else if (busy > 0) busy <= busy - 1;
  end

  // Register file model: the read value is only on the bus the cycle after rd_strobe.
  always @(posedge clk) rd_data <= rd_strobe ? rd_val : ~rd_val;

  // Compare process: every strobe must match the head of the expected stream.
  logic        prev_stb = 1'b0;
  logic [15:0] m_w;
  logic [7:0]  m_b;
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_strobe) begin
        if (exp_wr.size() == 0) chk(1'b0, "wr_unexpected", int'({reg_addr, wr_data}), 0);
        else begin
          m_w = exp_wr.pop_front();
          chk({reg_addr, wr_data} == m_w, "wr_access", int'({reg_addr, wr_data}), int'(m_w));
        end
      end
      if (rd_strobe) begin
        if (exp_rd.size() == 0) chk(1'b0, "rd_unexpected", int'(reg_addr), 0);
        else begin
          m_b = exp_rd.pop_front();
          chk(reg_addr == m_b, "rd_addr", int'(reg_addr), int'(m_b));
        end
      end
      if (txd_strobe) begin
        chk(txd_ready && !prev_stb, "tx_handshake", int'({txd_ready, prev_stb}), 2);
        if (exp_tx.size() == 0) chk(1'b0, "tx_unexpected", int'(txd), 0);
        else begin
          m_b = exp_tx.pop_front();
          chk(txd == m_b, "tx_byte", int'(txd), int'(m_b));
        end
      end
    end
    prev_stb = txd_strobe;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int hexval(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    return -1;
  endfunction

  function automatic logic [7:0] asc(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  function automatic logic [7:0] rand_hex_char();
    int n = $urandom_range(0, 15);
    if (n < 10) return 8'(48 + n);
    return ($urandom_range(0, 1) == 1) ? 8'(55 + n) : 8'(87 + n);
  endfunction

  // Line-level reference: outcome of a whole line (terminator excluded).
  task automatic model_line();
    int n = line_q.size();
    bit ok = 1'b1;
    int a;
    int d;
    if (n == 0) return;
    if ((line_q[0] == 8'h57 || line_q[0] == 8'h77) && n == 5) begin
      for (int i = 1; i < 5; i++) if (hexval(line_q[i]) < 0) ok = 1'b0;
      if (ok) begin
        a = hexval(line_q[1]) * 16 + hexval(line_q[2]);
        d = hexval(line_q[3]) * 16 + hexval(line_q[4]);
        exp_wr.push_back(16'(a * 256 + d));
        exp_tx.push_back(8'h4B);
        return;
      end
    end else if ((line_q[0] == 8'h52 || line_q[0] == 8'h72) && n == 3) begin
      for (int i = 1; i < 3; i++) if (hexval(line_q[i]) < 0) ok = 1'b0;
      if (ok) begin
        a = hexval(line_q[1]) * 16 + hexval(line_q[2]);
        exp_rd.push_back(8'(a));
        exp_tx.push_back(asc(int'(rd_val) / 16));
        exp_tx.push_back(asc(int'(rd_val) % 16));
        return;
      end
    end
    exp_tx.push_back(8'h3F);
  endtask

  task automatic set_line(input string s);
    line_q.delete();
    for (int i = 0; i < s.len(); i++) line_q.push_back(s[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxd = b;
    rxd_strobe = 1'b1;
    tick(1);
    rxd_strobe = 1'b0;
    rxd = 8'h00;
  endtask

  task automatic send_line(input logic [7:0] term, input int gap);
    foreach (line_q[i]) begin
      send_byte(line_q[i]);
      if (gap > 0) tick($urandom_range(0, gap));
    end
    send_byte(term);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_wr.size() + exp_rd.size() + exp_tx.size()) != 0 && t < 600) begin
      tick(1);
      t++;
    end
    chk(t < 600, {"drain_", name}, exp_wr.size() + exp_rd.size() + exp_tx.size(), 0);
    tick(4);
  endtask

  task automatic check_reset_vals(input string tag);
    chk(txd == 8'h00, {tag, "_txd"}, int'(txd), 0);
    chk(txd_strobe == 1'b0, {tag, "_txd_strobe"}, int'(txd_strobe), 0);
    chk(wr_strobe == 1'b0, {tag, "_wr_strobe"}, int'(wr_strobe), 0);
    chk(rd_strobe == 1'b0, {tag, "_rd_strobe"}, int'(rd_strobe), 0);
    chk(reg_addr == 8'h00, {tag, "_reg_addr"}, int'(reg_addr), 0);
    chk(wr_data == 8'h00, {tag, "_wr_data"}, int'(wr_data), 0);
  endtask

  task automatic clear_exp();
    exp_wr.delete();
    exp_rd.delete();
    exp_tx.delete();
  endtask

  initial begin
    string pool = "0123456789abcdefABCDEFWwRrGZx ";
    int kind;
    int len;

    // Pin the reference model against hand-computed results.
    set_line("W3CA5");
    model_line();
    chk(exp_wr.size() == 1 && exp_wr[0] == 16'h3CA5 && exp_tx.size() == 1 && exp_tx[0] == 8'h4B,
        "pin_model_write", exp_tx.size(), 1);
    clear_exp();
    rd_val = 8'h7E;
    set_line("r3c");
    model_line();
    chk(exp_rd.size() == 1 && exp_rd[0] == 8'h3C && exp_tx.size() == 2 &&
        exp_tx[0] == 8'h37 && exp_tx[1] == 8'h45, "pin_model_read", exp_tx.size(), 2);
    clear_exp();
    set_line("W12");
    model_line();
    chk(exp_wr.size() == 0 && exp_tx.size() == 1 && exp_tx[0] == 8'h3F,
        "pin_model_short", exp_tx.size(), 1);
    clear_exp();

    tick(3);
    reset = 1'b0;
    check_reset_vals("reset");

    // Directed write.
    set_line("W3CA5");
    exp_wr.push_back(16'h3CA5);
    exp_tx.push_back(8'h4B);
    send_line(CR, 0);
    drain("write");
    chk(reg_addr == 8'h3C, "write_addr_hold", int'(reg_addr), 8'h3C);
    chk(wr_data == 8'hA5, "write_data_hold", int'(wr_data), 8'hA5);

    // Directed read.
    rd_val = 8'h7E;
    set_line("r3c");
    exp_rd.push_back(8'h3C);
    exp_tx.push_back(8'h37);
    exp_tx.push_back(8'h45);
    send_line(LF, 0);
    drain("read");
    chk(wr_data == 8'hA5, "read_keeps_wr_data", int'(wr_data), 8'hA5);

    // Malformed lines.
    set_line("WZ1A5");   exp_tx.push_back(8'h3F); send_line(CR, 0); drain("err_badhex");
    set_line("W12");     exp_tx.push_back(8'h3F); send_line(CR, 0); drain("err_short");
    set_line("W12345");  exp_tx.push_back(8'h3F); send_line(CR, 0); drain("err_long");

    // Backpressure on a read reply, with a stray byte during the reply.
    hold_low = 1'b1;
    rd_val = 8'h5A;
    set_line("R01");
    exp_rd.push_back(8'h01);
    exp_tx.push_back(8'h35);
    exp_tx.push_back(8'h41);
    send_line(CR, 0);
    tick(10);
    send_byte(8'h5A);
    tick(90);
    chk(exp_tx.size() == 2, "bp_held", exp_tx.size(), 2);
    hold_low = 1'b0;
    drain("backpressure");

    // Bare terminators produce nothing.
    set_line(""); send_line(CR, 0); send_byte(LF); drain("crlf");

    // Reset mid-line.
    set_line("W3C");
    send_line(8'h43, 0);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check_reset_vals("midline_reset");
    set_line("A5");
    exp_tx.push_back(8'h3F);
    send_line(CR, 0);
    drain("after_reset");

    // Gap shorter than the timeout keeps the partial line.
    send_byte(8'h57);
    send_byte(8'h33);
    tick(900);
    set_line("CA5");
    exp_wr.push_back(16'h3CA5);
    exp_tx.push_back(8'h4B);
    send_line(CR, 0);
    drain("no_timeout");

    // Gap past the timeout abandons the partial line silently.
    send_byte(8'h57);
    send_byte(8'h33);
    tick(TO + 5);
    set_line("W0102");
    exp_wr.push_back(16'h0102);
    exp_tx.push_back(8'h4B);
    send_line(CR, 0);
    drain("timeout");

    // Randomized lines against the line-level model.
    for (int k = 0; k < 150; k++) begin
      rd_val = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 3);
      line_q.delete();
      if (kind == 0 || kind == 3) begin
        line_q.push_back(($urandom_range(0, 1) == 1) ? 8'h57 : 8'h77);
        repeat (4) line_q.push_back(rand_hex_char());
      end else if (kind == 1) begin
        line_q.push_back(($urandom_range(0, 1) == 1) ? 8'h52 : 8'h72);
        repeat (2) line_q.push_back(rand_hex_char());
      end else begin
        len = $urandom_range(0, 7);
        repeat (len) line_q.push_back(pool[$urandom_range(0, pool.len() - 1)]);
      end
      if (kind == 3) begin
        case ($urandom_range(0, 2))
          0: void'(line_q.pop_back());
          1: line_q.push_back(rand_hex_char());
          default: line_q[$urandom_range(1, line_q.size() - 1)] = 8'h47;
        endcase
      end
      model_line();
      send_line(($urandom_range(0, 1) == 1) ? CR : LF, 2);
      drain("random");
      if ($urandom_range(0, 3) == 0) begin
        send_byte(LF);
        tick(3);
      end
    end

    tick(10);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
